// File: rtl/wb_pkg.sv
// Shared widths and FSM state encoding for the register-file writeback port arbiter.
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_result_fifo.sv
// Small in-order FIFO holding long-latency unit results ({rd, data}) until a writeback slot is free.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == (PTR_W+1)'(0));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says the slot is empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (always first) and queued LU results,
// requesting a one-slot bubble when the oldest LU result has been starved too long.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pipe_we_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [XLEN-1:0]       pipe_wdata_i,
    input  logic                  lu_valid_i,
    input  logic [REG_ADDR_W-1:0] lu_waddr_i,
    input  logic [XLEN-1:0]       lu_wdata_i,
    output logic                  lu_ready_o,
    output logic                  stall_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]       rf_wdata_o
);
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W  = REG_ADDR_W + XLEN;

    wb_state_e             state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  stall_q, stall_d;
    logic                  ready_en_q, ready_en_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

    logic                  live_s, push_s, pop_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [FCNT_W-1:0]     fifo_count_s, fifo_count_next_s;
    logic [ENT_W-1:0]      head_s;

    // ready_en_q keeps lu_ready_o low through reset and raises it one cycle after release.
    assign lu_ready_o = ready_en_q && !fifo_full_s;
    assign stall_o    = stall_q;
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    wb_result_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({lu_waddr_i, lu_wdata_i}),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Port arbitration, wait counter and FSM next-state.
    always_comb begin
        live_s            = pipe_we_i && (pipe_waddr_i != REG_ADDR_W'(0));
        push_s            = lu_valid_i && lu_ready_o && (lu_waddr_i != REG_ADDR_W'(0));
        pop_s             = !live_s && !fifo_empty_s;
        fifo_count_next_s = fifo_count_s;
        wait_cnt_d        = wait_cnt_q;
        state_d           = state_q;
        ready_en_d        = 1'b1;
        rf_we_d           = 1'b0;
        rf_waddr_d        = rf_waddr_q;
        rf_wdata_d        = rf_wdata_q;

        case ({push_s, pop_s})
            2'b10:   fifo_count_next_s = fifo_count_s + FCNT_W'(1);
            2'b01:   fifo_count_next_s = fifo_count_s - FCNT_W'(1);
            default: fifo_count_next_s = fifo_count_s;
        endcase

        if (live_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr_i;
            rf_wdata_d = pipe_wdata_i;
        end else if (!fifo_empty_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_s[ENT_W-1:XLEN];
            rf_wdata_d = head_s[XLEN-1:0];
        end else begin
            rf_we_d    = 1'b0;
        end

        if (pop_s || fifo_empty_s) begin
            wait_cnt_d = CNT_W'(0);
        end else if (wait_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        // Starvation is judged on the updated count so the bubble request follows the Nth blocked cycle.
        case (state_q)
            IDLE: begin
                if (push_s) state_d = DRAIN;
                else        state_d = IDLE;
            end
            DRAIN: begin
                if (wait_cnt_d == CNT_W'(STARVE_LIMIT))   state_d = FORCE;
                else if (fifo_count_next_s == FCNT_W'(0)) state_d = IDLE;
                else                                      state_d = DRAIN;
            end
            FORCE: begin
                if (pop_s && (fifo_count_next_s != FCNT_W'(0))) state_d = DRAIN;
                else if (pop_s)                                 state_d = IDLE;
                else                                            state_d = FORCE;
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == FORCE);
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
            ready_en_q <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            ready_en_q <= ready_en_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipe priority, LU drain, starvation bubble, x0 filtering, mid-run reset.
module tb_wb_port_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        lu_valid_i;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        lu_ready_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pipe_we_i    (pipe_we_i),
        .pipe_waddr_i (pipe_waddr_i),
        .pipe_wdata_i (pipe_wdata_i),
        .lu_valid_i   (lu_valid_i),
        .lu_waddr_i   (lu_waddr_i),
        .lu_wdata_i   (lu_wdata_i),
        .lu_ready_o   (lu_ready_o),
        .stall_o      (stall_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [4:0]  exp_addr;
        rst_i        = 1'b1;
        pipe_we_i    = 1'b0;
        pipe_waddr_i = 5'd0;
        pipe_wdata_i = 32'd0;
        lu_valid_i   = 1'b0;
        lu_waddr_i   = 5'd0;
        lu_wdata_i   = 32'd0;

        // 1. Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_we",    32'(rf_we_o),    32'd0);
            check_eq("rst_stall", 32'(stall_o),    32'd0);
            check_eq("rst_ready", 32'(lu_ready_o), 32'd0);
        end
        check_eq("rst_waddr", 32'(rf_waddr_o), 32'd0);
        check_eq("rst_wdata", rf_wdata_o, 32'd0);
        rst_i = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'(lu_ready_o), 32'd1);
        check_eq("post_rst_we",    32'(rf_we_o),    32'd0);

        // 2. Pipe write x5 = 0x1234
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd5; pipe_wdata_i = 32'h1234;
        tick();
        check_eq("t2_we",    32'(rf_we_o),    32'd1);
        check_eq("t2_waddr", 32'(rf_waddr_o), 32'd5);
        check_eq("t2_wdata", rf_wdata_o,      32'h1234);
        pipe_we_i = 1'b0;
        tick();
        check_eq("t2_idle_we",   32'(rf_we_o),    32'd0);
        check_eq("t2_hold_addr", 32'(rf_waddr_o), 32'd5);
        check_eq("t2_hold_data", rf_wdata_o,      32'h1234);

        // 3. LU push x7 = 0xAA into idle pipe, drains two cycles after the push
        lu_valid_i = 1'b1; lu_waddr_i = 5'd7; lu_wdata_i = 32'hAA;
        tick();
        lu_valid_i = 1'b0;
        check_eq("t3_push_we", 32'(rf_we_o), 32'd0);
        tick();
        check_eq("t3_we",    32'(rf_we_o),    32'd1);
        check_eq("t3_waddr", 32'(rf_waddr_o), 32'd7);
        check_eq("t3_wdata", rf_wdata_o,      32'hAA);
        tick();
        check_eq("t3_after_we", 32'(rf_we_o), 32'd0);

        // 4. Fill under continuous live slots; third result held; bubble after 8 blocked cycles
        pipe_we_i = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            exp_addr     = 5'(16 + (c % 8));
            pipe_waddr_i = exp_addr;
            pipe_wdata_i = 32'h1000 + 32'(c);
            lu_valid_i   = 1'b1;
            if (c == 0) begin
                lu_waddr_i = 5'd8;  lu_wdata_i = 32'hB1;
            end else if (c == 1) begin
                lu_waddr_i = 5'd9;  lu_wdata_i = 32'hB2;
            end else begin
                lu_waddr_i = 5'd11; lu_wdata_i = 32'hB3;
            end
            tick();
            check_eq($sformatf("t4_we_c%0d", c),    32'(rf_we_o),    32'd1);
            check_eq($sformatf("t4_addr_c%0d", c),  32'(rf_waddr_o), 32'(exp_addr));
            check_eq($sformatf("t4_stall_c%0d", c), 32'(stall_o),    (c >= 8) ? 32'd1 : 32'd0);
            if (c <= 2) begin
                check_eq($sformatf("t4_ready_c%0d", c), 32'(lu_ready_o), (c == 0) ? 32'd1 : 32'd0);
            end
        end
        // First idle slot: head x8 pops, bubble request drops, room opens for x11
        pipe_we_i = 1'b0;
        tick();
        check_eq("t4_pop1_we",    32'(rf_we_o),    32'd1);
        check_eq("t4_pop1_addr",  32'(rf_waddr_o), 32'd8);
        check_eq("t4_pop1_data",  rf_wdata_o,      32'hB1);
        check_eq("t4_pop1_stall", 32'(stall_o),    32'd0);
        check_eq("t4_pop1_ready", 32'(lu_ready_o), 32'd1);
        tick();
        lu_valid_i = 1'b0;
        check_eq("t4_pop2_addr", 32'(rf_waddr_o), 32'd9);
        check_eq("t4_pop2_data", rf_wdata_o,      32'hB2);
        tick();
        check_eq("t4_pop3_we",   32'(rf_we_o),    32'd1);
        check_eq("t4_pop3_addr", 32'(rf_waddr_o), 32'd11);
        check_eq("t4_pop3_data", rf_wdata_o,      32'hB3);
        tick();
        check_eq("t4_drained_we", 32'(rf_we_o), 32'd0);

        // 5. Writes to x0 from both sources are ignored
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd0; pipe_wdata_i = 32'hBEEF;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd0; lu_wdata_i = 32'hDEAD;
        tick();
        pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        check_eq("t5_we",    32'(rf_we_o),    32'd0);
        check_eq("t5_ready", 32'(lu_ready_o), 32'd1);
        tick();
        check_eq("t5_no_drain_we", 32'(rf_we_o),    32'd0);
        check_eq("t5_hold_addr",   32'(rf_waddr_o), 32'd11);
        check_eq("t5_stall",       32'(stall_o),    32'd0);

        // 6. Reset with two queued entries and stall asserted
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h3333;
        for (int c = 0; c <= 8; c++) begin
            lu_valid_i = (c < 2) ? 1'b1 : 1'b0;
            lu_waddr_i = (c == 0) ? 5'd12 : 5'd13;
            lu_wdata_i = (c == 0) ? 32'hC1 : 32'hC2;
            tick();
        end
        check_eq("t6_pre_stall", 32'(stall_o),    32'd1);
        check_eq("t6_pre_ready", 32'(lu_ready_o), 32'd0);
        rst_i = 1'b1; pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        tick();
        check_eq("t6_rst_stall", 32'(stall_o),    32'd0);
        check_eq("t6_rst_we",    32'(rf_we_o),    32'd0);
        check_eq("t6_rst_addr",  32'(rf_waddr_o), 32'd0);
        rst_i = 1'b0;
        tick();
        check_eq("t6_ready", 32'(lu_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t6_no_stale_we_%0d", i), 32'(rf_we_o), 32'd0);
            check_eq($sformatf("t6_stall_%0d", i),       32'(stall_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
